// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting one of four requesters a burst of
// up/down counter steps; one burst at a time through IDLE/LOAD/RUN/DONE.
module counter_arbiter (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [3:0]  i_req,
   input  logic [7:0]  i_op,
   input  logic [15:0] i_len,
   output logic [3:0]  o_gnt,
   output logic [3:0]  o_done,
   output logic [1:0]  o_ctrl,
   output logic        o_cnt_en,
   output logic        o_busy,
   output logic [1:0]  o_owner
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [1:0] r_last;
   logic [3:0] r_len;
   logic [3:0] r_rem;

   logic [1:0] w_win;
   logic [1:0] w_idx;
   logic       w_any;
   logic [3:0] w_win_oh;

   // Scan from the highest offset down so the nearest requester after
   // the last owner is the final one to overwrite the winner.
   always_comb begin
      w_win = r_last + 2'd1;
      w_idx = r_last + 2'd1;
      w_any = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_last + 2'd1 + 2'(k);
         if (i_req[w_idx]) begin
            w_win = w_idx;
            w_any = 1'b1;
         end
      end
   end

   assign w_win_oh = 4'b0001 << w_win;

   // o_ctrl doubles as the latched step code for the whole burst.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_last   <= 2'd3;
         r_len    <= 4'd0;
         r_rem    <= 4'd0;
         o_gnt    <= 4'b0000;
         o_done   <= 4'b0000;
         o_ctrl   <= 2'b00;
         o_cnt_en <= 1'b0;
         o_busy   <= 1'b0;
         o_owner  <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_LOAD;
                  o_owner <= w_win;
                  o_gnt   <= w_win_oh;
                  o_ctrl  <= i_op[{w_win, 1'b0} +: 2];
                  r_len   <= i_len[{w_win, 2'b00} +: 4];
                  o_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (r_len == 4'd0) begin
                  r_state <= S_DONE;
                  o_done  <= o_gnt;
               end else begin
                  r_state  <= S_RUN;
                  r_rem    <= r_len;
                  o_cnt_en <= 1'b1;
               end
            end
            S_RUN: begin
               r_rem <= r_rem - 4'd1;
               if (r_rem == 4'd1) begin
                  r_state  <= S_DONE;
                  o_cnt_en <= 1'b0;
                  o_done   <= o_gnt;
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               r_last   <= o_owner;
               o_gnt    <= 4'b0000;
               o_done   <= 4'b0000;
               o_ctrl   <= 2'b00;
               o_cnt_en <= 1'b0;
               o_busy   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a burst scoreboard and a
// model of the shared up/down counter.
module tb_counter_arbiter;

   logic        i_clk;
   logic        i_reset;
   logic [3:0]  i_req;
   logic [7:0]  i_op;
   logic [15:0] i_len;
   logic [3:0]  o_gnt;
   logic [3:0]  o_done;
   logic [1:0]  o_ctrl;
   logic        o_cnt_en;
   logic        o_busy;
   logic [1:0]  o_owner;

   counter_arbiter dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_req    (i_req),
      .i_op     (i_op),
      .i_len    (i_len),
      .o_gnt    (o_gnt),
      .o_done   (o_done),
      .o_ctrl   (o_ctrl),
      .o_cnt_en (o_cnt_en),
      .o_busy   (o_busy),
      .o_owner  (o_owner)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [1:0] owner;
      logic [1:0] op;
      int         len;
      int         cnt;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   int   cyc      = 0;
   int   last_done_cyc = 0;
   int   model_cnt = 0;
   int   en_cnt = 0;
   int   gnt_cyc = 0;
   bit   in_burst = 0;
   bit   stable = 1;
   bit   chk_idle = 0;
   logic [1:0] b_ctrl;
   logic [3:0] b_gnt;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int step(input logic [1:0] c);
      case (c)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return -1;
         default: return -2;
      endcase
   endfunction

   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   task automatic check_reset(input string p);
      chk({p, "_gnt"},    32'(o_gnt),    32'd0);
      chk({p, "_done"},   32'(o_done),   32'd0);
      chk({p, "_ctrl"},   32'(o_ctrl),   32'd0);
      chk({p, "_cnt_en"}, 32'(o_cnt_en), 32'd0);
      chk({p, "_busy"},   32'(o_busy),   32'd0);
      chk({p, "_owner"},  32'(o_owner),  32'd0);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_req   = 4'b0000;
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   task automatic wait_gnt(input string tag, input logic [3:0] g,
                           input int budget);
      for (int i = 0; i < budget; i++) begin
         if (o_gnt === g) break;
         tick();
      end
      chk(tag, 32'(o_gnt), 32'(g));
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0 && o_busy === 1'b0) break;
         tick();
      end
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      chk({tag, "_busy"},     32'(o_busy),    32'd0);
   endtask

   // Burst monitor: tracks each grant window and checks it on done.
   always @(negedge i_clk) begin
      exp_t e;
      cyc++;
      if (i_reset) begin
         in_burst  = 0;
         chk_idle  = 0;
         model_cnt = 0;
      end else begin
         if (chk_idle) begin
            chk("idle_busy", 32'(o_busy), 32'd0);
            chk("idle_gnt",  32'(o_gnt),  32'd0);
            chk("idle_ctrl", 32'(o_ctrl), 32'd0);
            chk_idle = 0;
         end
         if (o_cnt_en === 1'b1) model_cnt += step(o_ctrl);
         if (o_gnt !== 4'b0000) begin
            if (!in_burst) begin
               in_burst = 1;
               en_cnt   = 0;
               gnt_cyc  = 0;
               stable   = 1;
               b_ctrl   = o_ctrl;
               b_gnt    = o_gnt;
            end
            gnt_cyc++;
            if (o_cnt_en === 1'b1) en_cnt++;
            if (o_ctrl !== b_ctrl || o_gnt !== b_gnt) stable = 0;
         end
         if (o_done !== 4'b0000) begin
            n_done++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(o_done), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_vec",   32'(o_done),  32'(4'b0001 << e.owner));
               chk("owner",      32'(o_owner), 32'(e.owner));
               chk("gnt_vec",    32'(b_gnt),   32'(4'b0001 << e.owner));
               chk("ctrl",       32'(b_ctrl),  32'(e.op));
               chk("stable",     32'(stable),  32'd1);
               chk("cnt_en_cyc", 32'(en_cnt),  32'(e.len));
               chk("gnt_cyc",    32'(gnt_cyc), 32'(e.len + 2));
               chk("counter",    32'(model_cnt), 32'(e.cnt));
               if (e.gap != 0)
                  chk("done_gap", 32'(cyc - last_done_cyc), 32'(e.gap));
            end
            last_done_cyc = cyc;
            in_burst = 0;
            chk_idle = 1;
         end
      end
   end

   initial begin
      int base;
      int k;
      i_reset = 1'b1;
      i_req   = 4'b0000;
      i_op    = 8'h00;
      i_len   = 16'h0000;
      tick();
      tick();
      check_reset("rst");

      // Single request, present before release: arbitrates at first edge.
      i_op  = 8'h00;
      i_len = 16'h0003;
      i_req = 4'b0001;
      sb.push_back('{2'd0, 2'b00, 3, 3, 0});
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      chk("s1_gnt",  32'(o_gnt),  32'b0001);
      chk("s1_busy", 32'(o_busy), 32'd1);
      chk("s1_load_en", 32'(o_cnt_en), 32'd0);
      i_req = 4'b0000;
      @(posedge i_clk); #1;
      chk("s1_en_first", 32'(o_cnt_en), 32'd1);
      chk("s1_ctrl",     32'(o_ctrl),   32'd0);
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      chk("s1_en_last", 32'(o_cnt_en), 32'd1);
      @(posedge i_clk); #1;
      chk("s1_done",   32'(o_done),   32'b0001);
      chk("s1_done_en", 32'(o_cnt_en), 32'd0);
      @(posedge i_clk); #1;
      chk("s1_idle_busy", 32'(o_busy), 32'd0);
      chk("s1_idle_done", 32'(o_done), 32'd0);
      wait_quiet("s1", 20);

      // Zero-length burst on requester 2 with op -1.
      do_reset();
      i_op  = 8'h20;
      i_len = 16'h0000;
      i_req = 4'b0100;
      sb.push_back('{2'd2, 2'b10, 0, 0, 0});
      wait_gnt("s2_gnt", 4'b0100, 10);
      i_req = 4'b0000;
      wait_quiet("s2", 20);

      // Round robin with every requester held.
      do_reset();
      i_op  = 8'h00;
      i_len = 16'h1111;
      i_req = 4'b1111;
      sb.push_back('{2'd0, 2'b00, 1, 1, 0});
      sb.push_back('{2'd1, 2'b00, 1, 2, 4});
      sb.push_back('{2'd2, 2'b00, 1, 3, 4});
      sb.push_back('{2'd3, 2'b00, 1, 4, 4});
      sb.push_back('{2'd0, 2'b00, 1, 5, 4});
      base = n_done;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (n_done - base >= 5) break;
      end
      chk("s3_dones", 32'(n_done - base), 32'd5);
      i_req = 4'b0000;
      wait_quiet("s3", 20);

      // Mixed ops on the shared counter: +2 x4 then -2 x2.
      do_reset();
      i_op  = 8'h0D;
      i_len = 16'h0024;
      i_req = 4'b0011;
      sb.push_back('{2'd0, 2'b01, 4, 8, 0});
      sb.push_back('{2'd1, 2'b11, 2, 4, 0});
      wait_gnt("s4_gnt0", 4'b0001, 10);
      i_req = 4'b0010;
      wait_gnt("s4_gnt1", 4'b0010, 20);
      i_req = 4'b0000;
      wait_quiet("s4", 20);

      // Owner drops req and changes op/len mid-burst.
      do_reset();
      i_op  = 8'h00;
      i_len = 16'h0005;
      i_req = 4'b0001;
      sb.push_back('{2'd0, 2'b00, 5, 5, 0});
      wait_gnt("s5_gnt", 4'b0001, 10);
      tick();
      tick();
      i_req = 4'b0000;
      i_op  = 8'h03;
      i_len = 16'h0001;
      wait_quiet("s5", 30);

      // Reset in the middle of a long burst; requester 0 wins afterwards.
      do_reset();
      i_op  = 8'h00;
      i_len = 16'hF000;
      i_req = 4'b1000;
      wait_gnt("s6_gnt3", 4'b1000, 10);
      k = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_cnt_en === 1'b1) k++;
         if (k == 5) break;
      end
      chk("s6_steps", 32'(k), 32'd5);
      i_req = 4'b1001;
      i_len = 16'hF001;
      #2;
      i_reset = 1'b1;
      #1;
      check_reset("s6_rst");
      tick();
      i_reset = 1'b0;
      sb.push_back('{2'd0, 2'b00, 1, 1, 0});
      wait_gnt("s6_gnt0", 4'b0001, 10);
      i_req = 4'b0000;
      wait_quiet("s6", 20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces reset state immediately, released synchronously by the environment.
REQ-003 req  input  4  per-requester request, level; bit i = requester i.
REQ-004 op  input  8  op[2i+1:2i] = requester i step code: 00 +1, 01 +2, 10 -1, 11 -2.
REQ-005 len  input  16  len[4i+3:4i] = requester i burst length in steps, 0..15.
REQ-006 gnt  output  4  one-hot grant to current owner; all-zero when idle.
REQ-007 done  output  4  one-cycle completion pulse to owner.
REQ-008 ctrl  output  2  step code driven to the up/down step counter.
REQ-009 cnt_en  output  1  counter advance enable; counter moves by ctrl only when high.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 owner  output  2  binary index of current or most recent owner.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, RUN, DONE; no other states reachable.
REQ-013 IDLE: if any req bit high, select winner round-robin, starting at (last_owner+1) mod 4 and wrapping; go to LOAD; else stay.
REQ-014 On IDLE->LOAD, the winner's op and len SHALL be latched; later changes to req/op/len for the owner SHALL be ignored until DONE.
REQ-015 LOAD: gnt[owner]=1, cnt_en=0; if latched len=0 go to DONE, else load remaining=len and go to RUN.
REQ-016 RUN: cnt_en=1 every cycle, remaining decrements each cycle; when remaining=1 go to DONE; exactly len cnt_en cycles per burst.
REQ-017 DONE: done[owner]=1 for exactly one cycle, gnt held, cnt_en=0; last_owner<=owner; next state IDLE.
REQ-018 gnt SHALL be one-hot from LOAD through DONE inclusive, zero in IDLE.
REQ-019 ctrl SHALL equal latched op in LOAD, RUN, DONE and 00 in IDLE.
REQ-020 Latency: req high at edge n in IDLE -> gnt at n+1, first cnt_en at n+2, done pulse at n+2+len.
REQ-021 Owner's req deasserting during LOAD/RUN SHALL NOT abort the burst.
REQ-022 A requester still holding req after its done SHALL only be re-granted after all other pending requesters per round-robin order.
REQ-023 Minimum cycle between consecutive bursts: DONE->IDLE->LOAD; one idle cycle with busy=0 SHALL always separate bursts.
REQ-024 Remaining counter is 4 bits; no wrap SHALL occur since RUN exits at remaining=1.

Reset
REQ-025 On reset assertion, asynchronously: state=IDLE, gnt=0000, done=0000, cnt_en=0, ctrl=00, busy=0, owner=00, last_owner=3 (requester 0 highest priority).
REQ-026 Reset mid-burst SHALL abort with no done pulse; latched op/len and remaining cleared to 0.
REQ-027 First arbitration after reset release SHALL occur at the first rising edge with reset low.

Verification
REQ-028 Single request: req=0001, op0=00, len0=3 -> gnt=0001 at n+1, cnt_en high n+2..n+4 with ctrl=00, done=0001 at n+5, model counter 0->3.
REQ-029 Zero length: req=0100, len2=0 -> gnt=0100 one LOAD cycle, no cnt_en, done=0100 next cycle, ctrl=op2 throughout.
REQ-030 Round-robin: req=1111 held, all len=1 -> grant order 0,1,2,3,0; each burst 4 cycles (LOAD,RUN,DONE,IDLE).
REQ-031 Mixed ops on shared counter: req0 op=01 len=4, then req1 op=11 len=2 -> counter 0->8->4, ctrl switches only across IDLE.
REQ-032 Input changes: owner drops req and changes op/len in RUN -> burst completes with latched values, done still pulses.
REQ-033 Reset mid-RUN (req3, len=15, reset after 5 steps) -> all outputs reset values immediately, no done, next grant goes to requester 0 if pending.
